// File: rtl/uart_transmit_controller_if.sv
// -----------------------------------------------------------------------------
// uart_transmit_controller_if
//
// Purpose:
//    Groups the host-side handshake of the UART transmitter into one bundle.
//    The host drives the load strobe and data and sees the status flags and
//    the serial line.
//
// Signals:
//    Enable     host -> tx   permits starting a new frame
//    Load_data  host -> tx   single-cycle strobe writing TX_data to the holding register
//    TX_data    host -> tx   byte to transmit (8 bits)
//    Full       tx -> host   holding register occupied
//    Busy       tx -> host   frame in progress or holding register occupied
//    Overrun    tx -> host   sticky: a load arrived while Full was set
//    UART_TX_O  tx -> line   registered serial output, idles high
//
// Modports:
//    master  host side (drives Enable/Load_data/TX_data)
//    slave   transmitter side (drives the status flags and the line)
// -----------------------------------------------------------------------------
interface uart_transmit_controller_if;
   logic       Enable;
   logic       Load_data;
   logic [7:0] TX_data;
   logic       Full;
   logic       Busy;
   logic       Overrun;
   logic       UART_TX_O;

   modport master (
      output Enable,
      output Load_data,
      output TX_data,
      input  Full,
      input  Busy,
      input  Overrun,
      input  UART_TX_O
   );

   modport slave (
      input  Enable,
      input  Load_data,
      input  TX_data,
      output Full,
      output Busy,
      output Overrun,
      output UART_TX_O
   );
endinterface : uart_transmit_controller_if

// File: rtl/uart_transmit_controller.sv
// -----------------------------------------------------------------------------
// uart_transmit_controller
//
// Purpose:
//    Serialises bytes onto the UART TX pin using 8N1 framing, LSB first.
//    A one-byte holding register double-buffers the shift register so the
//    host can queue the next byte while the current frame is on the line;
//    a queued byte follows the previous stop bit with no idle gap.
//
// Parameters:
//    CLOCK_RATE  Clock_50 cycles per bit period (legal 2..1023)
//
// Ports:
//    Clock_50  input   system clock, rising edge
//    Reset     input   synchronous, active-high reset
//    bus       slave   host handshake, status flags and serial line
//                      (see uart_transmit_controller_if)
// -----------------------------------------------------------------------------
module uart_transmit_controller #(
   parameter int CLOCK_RATE = 434
) (
   input  logic                          Clock_50,
   input  logic                          Reset,
   uart_transmit_controller_if.slave     bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   // Terminal value of the per-bit counter.
   localparam logic [9:0] LAST_COUNT = 10'(CLOCK_RATE - 1);

   state_e      state_q;
   logic [9:0]  clock_count_q;
   logic [2:0]  data_count_q;
   logic [7:0]  hold_q;
   logic [7:0]  shift_q;
   logic        full_q;
   logic        overrun_q;
   logic        tx_q;

   logic        bit_done;
   logic        start_frame;

   assign bit_done    = (clock_count_q == LAST_COUNT);
   // A held byte may begin a frame only while the host permits it.
   assign start_frame = full_q & bus.Enable;

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state_q       <= IDLE;
         clock_count_q <= '0;
         data_count_q  <= '0;
         hold_q        <= '0;
         shift_q       <= '0;
         full_q        <= 1'b0;
         overrun_q     <= 1'b0;
         tx_q          <= 1'b1;
      end else begin
         // Load handshake. It looks only at the registered Full, so a load
         // in the cycle the holding register empties is still refused.
         if (bus.Load_data) begin
            if (!full_q) begin
               hold_q    <= bus.TX_data;
               full_q    <= 1'b1;
               overrun_q <= 1'b0;
            end else begin
               overrun_q <= 1'b1;
            end
         end

         // NOTE: all state is updated with non-blocking assignments in this
         // one block; where the FSM below clears full_q it is the last write
         // and wins, while every read sees the value from before the edge.
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (start_frame) begin
                  shift_q       <= hold_q;
                  full_q        <= 1'b0;
                  tx_q          <= 1'b0;
                  clock_count_q <= '0;
                  state_q       <= START;
               end
            end

            START: begin
               tx_q <= 1'b0;
               if (bit_done) begin
                  clock_count_q <= '0;
                  data_count_q  <= '0;
                  tx_q          <= shift_q[0];
                  state_q       <= DATA;
               end else begin
                  clock_count_q <= clock_count_q + 10'd1;
               end
            end

            DATA: begin
               if (bit_done) begin
                  clock_count_q <= '0;
                  shift_q       <= {1'b0, shift_q[7:1]};
                  if (data_count_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     // shift_q[1] is the bit that reaches position 0 this edge.
                     tx_q         <= shift_q[1];
                     data_count_q <= data_count_q + 3'd1;
                  end
               end else begin
                  clock_count_q <= clock_count_q + 10'd1;
               end
            end

            STOP: begin
               tx_q <= 1'b1;
               if (bit_done) begin
                  clock_count_q <= '0;
                  if (start_frame) begin
                     // Back-to-back: next start bit directly after this stop bit.
                     shift_q <= hold_q;
                     full_q  <= 1'b0;
                     tx_q    <= 1'b0;
                     state_q <= START;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  clock_count_q <= clock_count_q + 10'd1;
               end
            end

            default: begin
               state_q       <= IDLE;
               clock_count_q <= '0;
               tx_q          <= 1'b1;
            end
         endcase
      end
   end

   assign bus.Full      = full_q;
   assign bus.Overrun   = overrun_q;
   assign bus.UART_TX_O = tx_q;
   assign bus.Busy      = (state_q != IDLE) | full_q;

endmodule : uart_transmit_controller
